// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator with shadowed period/duty/control registers,
// edge- or center-aligned counting and per-channel output inversion.

module pwm_multi_ctrl_lane #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] wdata,
  input  logic         load,
  input  logic         run,
  input  logic         inv,
  input  logic [W-1:0] cnt,
  output logic         pwm
);
  logic [W-1:0] duty_pend_q, duty_pend_d;
  logic [W-1:0] duty_q, duty_d;
  logic         pwm_q, pwm_d;

  always_comb begin
    duty_pend_d = we ? wdata : duty_pend_q;
    duty_d      = load ? duty_pend_q : duty_q;
    pwm_d       = run ? ((cnt < duty_q) ^ inv) : inv;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_pend_q <= '0;
      duty_q      <= '0;
      pwm_q       <= 1'b0;
    end else begin
      duty_pend_q <= duty_pend_d;
      duty_q      <= duty_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm = pwm_q;
endmodule

module pwm_multi_ctrl #(
  parameter int CH = 4,
  parameter int W  = 28,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CFG_WE,
  input  logic [AW-1:0] CFG_ADDR,
  input  logic [W-1:0]  CFG_WDATA,
  output logic [CH-1:0] PWM_OUT,
  output logic          PERIOD_END
);
  logic [W-1:0]    period_q, period_d, per_act_q, per_act_d, cnt_q, cnt_d;
  logic [CH+1:0]   ctrl_q, ctrl_d;
  logic [CH-1:0]   inv_q, inv_d, lane_we;
  logic            mode_q, mode_d, down_q, down_d, pe_q, pe_d;
  logic            run, at_top, boundary, load;

  // run is false while disabled or with a degenerate period (P < 2)
  assign run      = ctrl_q[0] && (per_act_q > W'(1));
  assign at_top   = (cnt_q == per_act_q - W'(1));
  assign boundary = run && (mode_q ? (down_q && cnt_q == '0) : at_top);
  assign load     = !run || boundary;

  always_comb begin
    period_d  = period_q;
    ctrl_d    = ctrl_q;
    if (CFG_WE && CFG_ADDR == AW'(0)) period_d = CFG_WDATA;
    if (CFG_WE && CFG_ADDR == AW'(1)) ctrl_d   = CFG_WDATA[CH+1:0];
    per_act_d = load ? period_q      : per_act_q;
    mode_d    = load ? ctrl_q[1]     : mode_q;
    inv_d     = load ? ctrl_q[CH+1:2] : inv_q;
    pe_d      = boundary;
    cnt_d     = '0;
    down_d    = 1'b0;
    if (run) begin
      if (!mode_q) begin
        cnt_d = at_top ? '0 : cnt_q + W'(1);
      end else if (!down_q) begin
        if (at_top) begin
          cnt_d  = cnt_q - W'(1);
          down_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + W'(1);
        end
      end else if (cnt_q == '0) begin
        cnt_d = W'(1);
      end else begin
        cnt_d  = cnt_q - W'(1);
        down_d = 1'b1;
      end
      // mode switch or a newly degenerate period restarts from 0 counting up
      if (boundary && (ctrl_q[1] != mode_q || period_q < W'(2))) begin
        cnt_d  = '0;
        down_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      period_q  <= '0;
      ctrl_q    <= '0;
      per_act_q <= '0;
      mode_q    <= 1'b0;
      inv_q     <= '0;
      cnt_q     <= '0;
      down_q    <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      period_q  <= period_d;
      ctrl_q    <= ctrl_d;
      per_act_q <= per_act_d;
      mode_q    <= mode_d;
      inv_q     <= inv_d;
      cnt_q     <= cnt_d;
      down_q    <= down_d;
      pe_q      <= pe_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < CH; g++) begin : g_lane
      assign lane_we[g] = CFG_WE && (CFG_ADDR == AW'(g + 2));
      pwm_multi_ctrl_lane #(.W(W)) u_lane (
        .clk   (CLK),
        .rst   (RST),
        .we    (lane_we[g]),
        .wdata (CFG_WDATA),
        .load  (load),
        .run   (run),
        .inv   (inv_q[g]),
        .cnt   (cnt_q),
        .pwm   (PWM_OUT[g])
      );
    end
  endgenerate

  assign PERIOD_END = pe_q;
endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl: a register/polarity vector table plus
// hand-written edge, shadow, center, degenerate and reset sequences.

module tb_pwm_multi_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CFG_WE = 1'b0;
  logic [3:0]  CFG_ADDR = '0;
  logic [27:0] CFG_WDATA = '0;
  logic [3:0]  PWM_OUT;
  logic        PERIOD_END;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  pwm_multi_ctrl #(.CH(4), .W(28), .AW(4)) dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
    .CFG_WDATA(CFG_WDATA), .PWM_OUT(PWM_OUT), .PERIOD_END(PERIOD_END)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  addr;
    logic [27:0] wdata;
    logic [3:0]  exp_pwm;
    logic        exp_pe;
  } vec_t;

  task automatic tick(input logic rst, input logic we, input logic [3:0] a, input logic [27:0] d);
    RST = rst; CFG_WE = we; CFG_ADDR = a; CFG_WDATA = d;
    @(posedge CLK);
    #1;
    RST = 1'b0; CFG_WE = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [27:0] d);
    tick(1'b0, 1'b1, a, d);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 4'd0, 28'd0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // One 10-cycle edge-mode period; ch3 has duty 12 (always 1), ch1/ch2 duty 0.
  task automatic edge_period(input int d0, input int wi, input int wd);
    for (int i = 0; i < 10; i++) begin
      if (i == wi) wr(4'd2, 28'(wd));
      else idle();
      chk($sformatf("edge_pwm d=%0d i=%0d", d0, i), int'(PWM_OUT), 8 | ((i < d0) ? 1 : 0));
      chk($sformatf("edge_pe d=%0d i=%0d", d0, i), int'(PERIOD_END), (i == 9) ? 1 : 0);
    end
  endtask

  vec_t vecs[11];
  int   cexp[30];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'd0,  28'h0,  4'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 4'd1,  28'h3D, 4'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd0,  28'h0,  4'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'd0,  28'h0,  4'h0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'd1,  28'h10, 4'h0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'd0,  28'h0,  4'h0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'd0,  28'h0,  4'h4, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'd15, 28'h0,  4'h4, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'd1,  28'h0,  4'h4, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'd0,  28'h0,  4'h4, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'd0,  28'h0,  4'h0, 1'b0};
    cexp = '{0,1,2,3,4,3,2,1,0, 1,2,3,4,3,2,1,0, 1,2,3,4,3,2,1,0, 0,1,2,3,4};

    // reset state, write during reset, INV with EN=0, ignored address
    for (int v = 0; v < 11; v++) begin
      tick(vecs[v].rst, vecs[v].we, vecs[v].addr, vecs[v].wdata);
      chk($sformatf("vec%0d_pwm", v), int'(PWM_OUT), int'(vecs[v].exp_pwm));
      chk($sformatf("vec%0d_pe", v), int'(PERIOD_END), int'(vecs[v].exp_pe));
    end

    // edge mode, duty extremes, shadowed duty updates
    tick(1'b1, 1'b0, 4'd0, 28'd0);
    wr(4'd0, 28'd10);
    wr(4'd2, 28'd3);
    wr(4'd5, 28'd12);
    wr(4'd1, 28'd1);
    edge_period(3, -1, 0);
    edge_period(3, -1, 0);
    edge_period(3, 4, 7);
    edge_period(7, 9, 5);
    edge_period(7, -1, 0);
    edge_period(5, -1, 0);

    // reset mid-period with a dropped CTRL write
    idle();
    tick(1'b1, 1'b1, 4'd1, 28'h3D);
    chk("rst_mid_pwm", int'(PWM_OUT), 0);
    chk("rst_mid_pe", int'(PERIOD_END), 0);
    for (int i = 0; i < 12; i++) begin
      idle();
      chk($sformatf("post_rst_pwm%0d", i), int'(PWM_OUT), 0);
      chk($sformatf("post_rst_pe%0d", i), int'(PERIOD_END), 0);
    end

    // reset on the boundary cycle: no PERIOD_END
    wr(4'd0, 28'd10);
    wr(4'd1, 28'd1);
    for (int i = 0; i < 9; i++) idle();
    tick(1'b1, 1'b0, 4'd0, 28'd0);
    chk("rst_bnd_pe", int'(PERIOD_END), 0);
    idle();
    chk("rst_bnd_pe2", int'(PERIOD_END), 0);

    // center mode P=5, DUTY[1]=2, then switch to edge mode at a boundary
    tick(1'b1, 1'b0, 4'd0, 28'd0);
    wr(4'd0, 28'd5);
    wr(4'd3, 28'd2);
    wr(4'd1, 28'd2);
    wr(4'd1, 28'd3);
    for (int k = 1; k <= 30; k++) begin
      if (k == 18) wr(4'd1, 28'd1);
      else idle();
      chk($sformatf("ctr_pwm k=%0d", k), int'(PWM_OUT), (cexp[k-1] < 2) ? 2 : 0);
      chk($sformatf("ctr_pe k=%0d", k), int'(PERIOD_END),
          (k == 9 || k == 17 || k == 25 || k == 30) ? 1 : 0);
    end

    // degenerate periods 0 and 1 with INV[2]=1, EN=1
    tick(1'b1, 1'b0, 4'd0, 28'd0);
    wr(4'd2, 28'd5);
    wr(4'd1, 28'h11);
    for (int k = 1; k <= 6; k++) begin
      idle();
      if (k >= 2) chk($sformatf("deg0_pwm%0d", k), int'(PWM_OUT), 4);
      chk($sformatf("deg0_pe%0d", k), int'(PERIOD_END), 0);
    end
    wr(4'd0, 28'd1);
    for (int k = 1; k <= 6; k++) begin
      idle();
      chk($sformatf("deg1_pwm%0d", k), int'(PWM_OUT), 4);
      chk($sformatf("deg1_pe%0d", k), int'(PERIOD_END), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
